clk_div_ctrl: RTL and testbench

Runtime-programmable clock-divider controller for the FPGA ALTERA DE2-115 designs. It replaces the fixed-rate divider wherever firmware or a top-level FSM must change the divided rate, start or stop it, or emit a fixed burst of periods. Rate changes are applied only at period boundaries, so `clk_div` never produces a runt phase. It sits between the `fpga_clk` domain and any logic clocked or enabled by the slow clock.

---
 rtl/clk_div_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_clk_div_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// Runtime-programmable clock divider with burst, stop/drain and a shadowed config handshake.
// Define CLK_DIV_CTRL_TICK_EN to build the tick pulse register; otherwise tick is tied to 0.
module clk_div_ctrl #(
    parameter int unsigned      CNT_W        = 26,
    parameter int unsigned      BURST_W      = 16,
    parameter logic [CNT_W-1:0] DEFAULT_HALF = 26'd250000
) (
    input  logic               fpga_clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_half,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               start,
    input  logic               stop,
    output logic               clk_div,
    output logic               tick,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   half_cnt_q, half_cnt_d;
    logic [BURST_W-1:0] period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0]   act_half_q, act_half_d;
    logic [BURST_W-1:0] act_burst_q, act_burst_d;
    logic [CNT_W-1:0]   shd_half_q, shd_half_d;
    logic [BURST_W-1:0] shd_burst_q, shd_burst_d;
    logic               pend_q, pend_d;
    logic               clk_div_q, clk_div_d;
    logic               done_q, done_d;
    logic               cfg_err_q, cfg_err_d;

    logic               toggle, fall, burst_hit, apply, go_idle;
    logic [BURST_W-1:0] period_inc;

    assign cfg_ready = (state_q == StIdle) || !pend_q;
    assign busy      = (state_q != StIdle);
    assign clk_div   = clk_div_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;

    always_comb begin
        state_d      = state_q;
        half_cnt_d   = half_cnt_q;
        period_cnt_d = period_cnt_q;
        act_half_d   = act_half_q;
        act_burst_d  = act_burst_q;
        shd_half_d   = shd_half_q;
        shd_burst_d  = shd_burst_q;
        pend_d       = pend_q;
        clk_div_d    = clk_div_q;
        done_d       = 1'b0;
        cfg_err_d    = 1'b0;
        apply        = 1'b0;
        go_idle      = 1'b0;

        toggle     = (half_cnt_q >= act_half_q - CNT_W'(1));
        fall       = toggle && clk_div_q;
        // Saturate so a long continuous run never wraps into a false burst match.
        period_inc = (period_cnt_q == '1) ? period_cnt_q : period_cnt_q + BURST_W'(1);
        burst_hit  = (act_burst_q != '0) && (period_inc == act_burst_q);

        if (state_q != StIdle) begin
            if (toggle) begin
                half_cnt_d = '0;
                clk_div_d  = !clk_div_q;
                if (clk_div_q) period_cnt_d = period_inc;
            end else begin
                half_cnt_d = half_cnt_q + CNT_W'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                clk_div_d    = 1'b0;
                half_cnt_d   = '0;
                period_cnt_d = '0;
                apply        = pend_q;
                if (start && !stop) begin
                    state_d   = StRun;
                    clk_div_d = 1'b1;
                end
            end
            StRun: begin
                if (stop && !clk_div_q) begin
                    go_idle = 1'b1;
                end else if (fall && (burst_hit || stop)) begin
                    go_idle = 1'b1;
                end else if (fall) begin
                    apply = pend_q;
                end else if (stop) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (fall) go_idle = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        if (go_idle) begin
            state_d      = StIdle;
            clk_div_d    = 1'b0;
            half_cnt_d   = '0;
            period_cnt_d = '0;
            done_d       = 1'b1;
            apply        = pend_q;
        end

        if (apply) begin
            act_half_d   = shd_half_q;
            act_burst_d  = shd_burst_q;
            pend_d       = 1'b0;
            period_cnt_d = '0;
        end

        // A direct load in IDLE is newer than any shadow value, so it wins.
        if (cfg_valid && cfg_ready) begin
            if (cfg_half == '0) begin
                cfg_err_d = 1'b1;
            end else if (state_q == StIdle) begin
                act_half_d  = cfg_half;
                act_burst_d = cfg_burst;
                pend_d      = 1'b0;
            end else begin
                shd_half_d  = cfg_half;
                shd_burst_d = cfg_burst;
                pend_d      = 1'b1;
            end
        end
    end

    always_ff @(posedge fpga_clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            half_cnt_q   <= '0;
            period_cnt_q <= '0;
            act_half_q   <= DEFAULT_HALF;
            act_burst_q  <= '0;
            shd_half_q   <= '0;
            shd_burst_q  <= '0;
            pend_q       <= 1'b0;
            clk_div_q    <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            half_cnt_q   <= half_cnt_d;
            period_cnt_q <= period_cnt_d;
            act_half_q   <= act_half_d;
            act_burst_q  <= act_burst_d;
            shd_half_q   <= shd_half_d;
            shd_burst_q  <= shd_burst_d;
            pend_q       <= pend_d;
            clk_div_q    <= clk_div_d;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

`ifdef CLK_DIV_CTRL_TICK_EN
    logic tick_q;

    // First cycle of every high phase, including the one that starts a run.
    always_ff @(posedge fpga_clk or negedge rst) begin
        if (!rst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= clk_div_d && !clk_div_q;
        end
    end

    assign tick = tick_q;
`else
    assign tick = 1'b0;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed scenarios plus randomized bursts
// checked against an arithmetic waveform model.
module tb_clk_div_ctrl;
    localparam int unsigned CNT_W   = 26;
    localparam int unsigned BURST_W = 16;
    localparam int          DEF_H   = 5;
`ifdef CLK_DIV_CTRL_TICK_EN
    localparam bit TICK_ON = 1'b1;
`else
    localparam bit TICK_ON = 1'b0;
`endif

    logic               fpga_clk = 1'b0;
    logic               rst = 1'b0;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [CNT_W-1:0]   cfg_half = '0;
    logic [BURST_W-1:0] cfg_burst = '0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               clk_div, tick, busy, done, cfg_err;

    int tests = 0;
    int fails = 0;

    always #5 fpga_clk = ~fpga_clk;

    clk_div_ctrl #(
        .CNT_W(CNT_W),
        .BURST_W(BURST_W),
        .DEFAULT_HALF(CNT_W'(DEF_H))
    ) dut (
        .fpga_clk(fpga_clk),
        .rst(rst),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_half(cfg_half),
        .cfg_burst(cfg_burst),
        .start(start),
        .stop(stop),
        .clk_div(clk_div),
        .tick(tick),
        .busy(busy),
        .done(done),
        .cfg_err(cfg_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge fpga_clk);
        #1;
    endtask

    // Cycle c counts from 1 = first cycle after the start edge; the run ends at
    // the B-th falling toggle, which lands after (2B-1)*H high/low half periods.
    function automatic int end_cycle(input int h, input int b);
        if (b == 0) return 32'h7fff_ffff;
        return (2 * b - 1) * h + 1;
    endfunction

    function automatic logic exp_high(input int c, input int h, input int b);
        if (c >= end_cycle(h, b)) return 1'b0;
        return ((c - 1) % (2 * h)) < h;
    endfunction

    task automatic cfg(input int h, input int b);
        cfg_valid = 1'b1;
        cfg_half  = CNT_W'(h);
        cfg_burst = BURST_W'(b);
        chk("cfg_ready_idle", cfg_ready, 1);
        step();
        cfg_valid = 1'b0;
        chk("cfg_err_legal", cfg_err, 0);
    endtask

    task automatic run_check(input int h, input int b, input int n);
        int e;
        e = end_cycle(h, b);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= n; c++) begin
            if (c > 1) step();
            chk($sformatf("clk_div h%0d b%0d c%0d", h, b, c), clk_div, exp_high(c, h, b));
            chk($sformatf("tick h%0d b%0d c%0d", h, b, c), tick,
                TICK_ON && (c < e) && (((c - 1) % (2 * h)) == 0));
            chk($sformatf("busy h%0d b%0d c%0d", h, b, c), busy, c < e);
            chk($sformatf("done h%0d b%0d c%0d", h, b, c), done, c == e);
        end
    endtask

    task automatic stop_low();
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_low_done", done, 1);
        chk("stop_low_busy", busy, 0);
        chk("stop_low_clk", clk_div, 0);
        step();
        chk("stop_low_done_once", done, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_clk_div"}, clk_div, 0);
        chk({tag, "_tick"}, tick, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_cfg_err"}, cfg_err, 0);
        chk({tag, "_cfg_ready"}, cfg_ready, 1);
    endtask

    initial begin
        int h, b;
        #3;
        chk_reset_outputs("in_reset");
        step();
        rst = 1'b1;
        step();
        chk_reset_outputs("after_reset");

        // Continuous H=3: high 1-3, low 4-6, tick at 1 and 7; stop while low.
        cfg(3, 0);
        run_check(3, 0, 11);
        stop_low();

        // Burst of two periods at H=2.
        cfg(2, 2);
        run_check(2, 2, 10);

        // Illegal half is rejected and the previous H=2/B=2 survives.
        cfg_valid = 1'b1;
        cfg_half  = '0;
        cfg_burst = BURST_W'(7);
        step();
        cfg_valid = 1'b0;
        chk("cfg_err_pulse", cfg_err, 1);
        step();
        chk("cfg_err_once", cfg_err, 0);
        run_check(2, 2, 9);

        // Live change H=4 -> H=2 offered during the high phase.
        cfg(4, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        cfg_valid = 1'b1;
        cfg_half  = CNT_W'(2);
        cfg_burst = '0;
        chk("live_ready_offer", cfg_ready, 1);
        step();
        cfg_valid = 1'b0;
        for (int c = 3; c <= 10; c++) begin
            if (c > 3) step();
            chk($sformatf("live_clk c%0d", c), clk_div, (c <= 4) || (c == 7) || (c == 8));
            chk($sformatf("live_ready c%0d", c), cfg_ready, c >= 5);
        end
        stop_low();

        // Stop one cycle into the high phase at H=5: drains, falls 4 cycles later.
        cfg(5, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b1;
        step();
        stop  = 1'b0;
        start = 1'b1;
        for (int c = 2; c <= 7; c++) begin
            if (c > 2) step();
            chk($sformatf("drain_clk c%0d", c), clk_div, c <= 5);
            chk($sformatf("drain_busy c%0d", c), busy, c <= 5);
            chk($sformatf("drain_done c%0d", c), done, c == 6);
            if (c == 5) start = 1'b0;
        end

        // H=1 boundary: toggles every cycle.
        cfg(1, 3);
        run_check(1, 3, 8);

        for (int i = 0; i < 6; i++) begin
            h = int'($urandom_range(1, 6));
            b = int'($urandom_range(1, 4));
            cfg(h, b);
            run_check(h, b, end_cycle(h, b) + 2);
        end

        // Reset mid-run with a pending config: outputs clear at once, pending is lost.
        cfg(3, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        cfg_valid = 1'b1;
        cfg_half  = CNT_W'(2);
        cfg_burst = '0;
        step();
        cfg_valid = 1'b0;
        chk("pending_ready", cfg_ready, 0);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        step();
        step();
        rst = 1'b1;
        step();
        run_check(DEF_H, 0, 8);
        stop_low();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
